// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter
// Turns one CPU commit record into an ASCII trace line, one character per
// char_valid/char_ready handshake:
//   ^<time>@<pc>:$<reg><=<data>#   (register write)
//   ^<time>@<pc>:*<addr><=<data>#  (memory write)
// Build option: define CPU_TRACE_SPACE_EN to insert a space after ':',
// before '<' and after '=' (three extra characters per line).
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The record side is ready only in IDLE. The
// character side holds char/char_valid stable until char_ready is seen, and
// char_valid stays high from '^' through '#' without gaps.
// dbg_state exposes the FSM state for checkers (IDLE encodes as 0).

module cpu_trace_emitter (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_kind,
   input  logic [15:0] in_time,
   input  logic [31:0] in_pc,
   input  logic [4:0]  in_reg,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   output logic [7:0]  char,
   output logic        char_valid,
   input  logic        char_ready,
   output logic [15:0] rec_cnt,
   output logic [3:0]  dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_CARET = 4'd1,
      S_TIME  = 4'd2,
      S_AT    = 4'd3,
      S_PC    = 4'd4,
      S_COLON = 4'd5,
      S_SP1   = 4'd6,
      S_KIND  = 4'd7,
      S_NUM   = 4'd8,
      S_SP2   = 4'd9,
      S_LT    = 4'd10,
      S_EQ    = 4'd11,
      S_SP3   = 4'd12,
      S_DATA  = 4'd13,
      S_HASH  = 4'd14
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [3:0]  dig_idx;
   logic [3:0]  idx_n;
   logic        line_done;

   // captured record
   logic        r_kind;
   logic [15:0] r_time;
   logic [31:0] r_pc;
   logic [4:0]  r_reg;
   logic [31:0] r_addr;
   logic [31:0] r_data;

   // time formatting helpers
   logic [1:0]  t_skip;
   logic [1:0]  t_sel;
   logic [3:0]  t_nib;
   logic [3:0]  t_dig;
   logic        t_last;

   // register number formatting helpers
   logic [1:0]  reg_tens;
   logic [4:0]  reg_tens_x10;
   logic [4:0]  reg_ones;
   logic        reg_two;
   logic [7:0]  num_char;
   logic        num_last;

   // Hex digit of a 32-bit word, position 0 is the most significant nibble.
   function automatic logic [3:0] hex_nib(input logic [31:0] v, input logic [2:0] pos);
      logic [3:0] n;
      case (pos)
         3'd0:    n = v[31:28];
         3'd1:    n = v[27:24];
         3'd2:    n = v[23:20];
         3'd3:    n = v[19:16];
         3'd4:    n = v[15:12];
         3'd5:    n = v[11:8];
         3'd6:    n = v[7:4];
         default: n = v[3:0];
      endcase
      return n;
   endfunction

   // Lowercase ASCII for one hex nibble.
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      logic [7:0] c;
      if (n < 4'd10) c = 8'h30 + {4'h0, n};
      else           c = 8'h57 + {4'h0, n};
      return c;
   endfunction

   // Leading-zero suppression for the BCD time: skip zero nibbles but always keep the last.
   always_comb begin
      if      (r_time[15:12] != 4'h0) t_skip = 2'd0;
      else if (r_time[11:8]  != 4'h0) t_skip = 2'd1;
      else if (r_time[7:4]   != 4'h0) t_skip = 2'd2;
      else                            t_skip = 2'd3;
      t_sel  = dig_idx[1:0] + t_skip;
      t_last = (dig_idx[1:0] == (2'd3 - t_skip));
      case (t_sel)
         2'd0:    t_nib = r_time[15:12];
         2'd1:    t_nib = r_time[11:8];
         2'd2:    t_nib = r_time[7:4];
         default: t_nib = r_time[3:0];
      endcase
      // non-decimal nibbles print as 9
      t_dig = (t_nib > 4'd9) ? 4'd9 : t_nib;
   end

   // Register number / address digit selection for the NUM field.
   always_comb begin
      if      (r_reg >= 5'd30) reg_tens = 2'd3;
      else if (r_reg >= 5'd20) reg_tens = 2'd2;
      else if (r_reg >= 5'd10) reg_tens = 2'd1;
      else                     reg_tens = 2'd0;
      case (reg_tens)
         2'd0:    reg_tens_x10 = 5'd0;
         2'd1:    reg_tens_x10 = 5'd10;
         2'd2:    reg_tens_x10 = 5'd20;
         default: reg_tens_x10 = 5'd30;
      endcase
      reg_ones = r_reg - reg_tens_x10;
      reg_two  = (r_reg >= 5'd10);
      if (r_kind) begin
         num_char = hex_char(hex_nib(r_addr, dig_idx[2:0]));
         num_last = (dig_idx == 4'd7);
      end else if (reg_two && dig_idx == 4'd0) begin
         num_char = 8'h30 + {6'b000000, reg_tens};
         num_last = 1'b0;
      end else begin
         num_char = 8'h30 + {3'b000, reg_ones};
         num_last = 1'b1;
      end
   end

   // Next-state and output decode: each state shows its character until it is accepted.
   always_comb begin
      state_n    = state;
      idx_n      = dig_idx;
      char       = 8'h00;
      char_valid = 1'b0;
      in_ready   = 1'b0;
      line_done  = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_n = S_CARET;
               idx_n   = 4'd0;
            end
         end
         S_CARET: begin
            char       = 8'h5e;
            char_valid = 1'b1;
            if (char_ready) begin
               state_n = S_TIME;
               idx_n   = 4'd0;
            end
         end
         S_TIME: begin
            char       = 8'h30 + {4'h0, t_dig};
            char_valid = 1'b1;
            if (char_ready) begin
               if (t_last) begin
                  state_n = S_AT;
                  idx_n   = 4'd0;
               end else begin
                  idx_n = dig_idx + 4'd1;
               end
            end
         end
         S_AT: begin
            char       = 8'h40;
            char_valid = 1'b1;
            if (char_ready) begin
               state_n = S_PC;
               idx_n   = 4'd0;
            end
         end
         S_PC: begin
            char       = hex_char(hex_nib(r_pc, dig_idx[2:0]));
            char_valid = 1'b1;
            if (char_ready) begin
               if (dig_idx == 4'd7) begin
                  state_n = S_COLON;
                  idx_n   = 4'd0;
               end else begin
                  idx_n = dig_idx + 4'd1;
               end
            end
         end
         S_COLON: begin
            char       = 8'h3a;
            char_valid = 1'b1;
            if (char_ready) begin
`ifdef CPU_TRACE_SPACE_EN
               state_n = S_SP1;
`else
               state_n = S_KIND;
`endif
            end
         end
         S_SP1: begin
            char       = 8'h20;
            char_valid = 1'b1;
            if (char_ready) state_n = S_KIND;
         end
         S_KIND: begin
            char       = r_kind ? 8'h2a : 8'h24;
            char_valid = 1'b1;
            if (char_ready) begin
               state_n = S_NUM;
               idx_n   = 4'd0;
            end
         end
         S_NUM: begin
            char       = num_char;
            char_valid = 1'b1;
            if (char_ready) begin
               if (num_last) begin
`ifdef CPU_TRACE_SPACE_EN
                  state_n = S_SP2;
`else
                  state_n = S_LT;
`endif
                  idx_n   = 4'd0;
               end else begin
                  idx_n = dig_idx + 4'd1;
               end
            end
         end
         S_SP2: begin
            char       = 8'h20;
            char_valid = 1'b1;
            if (char_ready) state_n = S_LT;
         end
         S_LT: begin
            char       = 8'h3c;
            char_valid = 1'b1;
            if (char_ready) state_n = S_EQ;
         end
         S_EQ: begin
            char       = 8'h3d;
            char_valid = 1'b1;
            if (char_ready) begin
`ifdef CPU_TRACE_SPACE_EN
               state_n = S_SP3;
`else
               state_n = S_DATA;
`endif
               idx_n   = 4'd0;
            end
         end
         S_SP3: begin
            char       = 8'h20;
            char_valid = 1'b1;
            if (char_ready) begin
               state_n = S_DATA;
               idx_n   = 4'd0;
            end
         end
         S_DATA: begin
            char       = hex_char(hex_nib(r_data, dig_idx[2:0]));
            char_valid = 1'b1;
            if (char_ready) begin
               if (dig_idx == 4'd7) begin
                  state_n = S_HASH;
                  idx_n   = 4'd0;
               end else begin
                  idx_n = dig_idx + 4'd1;
               end
            end
         end
         S_HASH: begin
            char       = 8'h23;
            char_valid = 1'b1;
            if (char_ready) begin
               state_n   = S_IDLE;
               idx_n     = 4'd0;
               line_done = 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            idx_n   = 4'd0;
         end
      endcase
   end

   // State, digit index and completed-line counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         dig_idx <= 4'd0;
         rec_cnt <= 16'h0000;
      end else begin
         state   <= state_n;
         dig_idx <= idx_n;
         if (line_done) rec_cnt <= rec_cnt + 16'h0001;
      end
   end

   // Record capture on acceptance; the fields stay frozen for the whole line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_kind <= 1'b0;
         r_time <= 16'h0000;
         r_pc   <= 32'h0000_0000;
         r_reg  <= 5'd0;
         r_addr <= 32'h0000_0000;
         r_data <= 32'h0000_0000;
      end else if (state == S_IDLE && in_valid) begin
         r_kind <= in_kind;
         r_time <= in_time;
         r_pc   <= in_pc;
         r_reg  <= in_reg;
         r_addr <= in_addr;
         r_data <= in_data;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: fixed trace lines, backpressure, back-to-back
// records, reset mid-line and randomized records against a string-level model.

module tb_cpu_trace_emitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_kind;
   logic [15:0] in_time;
   logic [31:0] in_pc;
   logic [4:0]  in_reg;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [7:0]  char;
   logic        char_valid;
   logic        char_ready;
   logic [15:0] rec_cnt;
   logic [3:0]  dbg_state;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] exp_cnt = 16'h0000;
   logic [7:0]  exp_q[$];

   cpu_trace_emitter dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_kind    (in_kind),
      .in_time    (in_time),
      .in_pc      (in_pc),
      .in_reg     (in_reg),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .char       (char),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .rec_cnt    (rec_cnt),
      .dbg_state  (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   // Reference line built from the format rules with string formatting.
   task automatic push_model(input logic k, input logic [15:0] t, input logic [31:0] pc,
                             input logic [4:0] r, input logic [31:0] addr, input logic [31:0] d);
      int    tv;
      int    nb;
      string s;
      tv = 0;
      for (int i = 3; i >= 0; i--) begin
         nb = int'((t >> (4 * i)) & 16'h000f);
         if (nb > 9) nb = 9;
         tv = tv * 10 + nb;
      end
      s = {"^", $sformatf("%0d", tv), "@", $sformatf("%08h", pc), ":"};
`ifdef CPU_TRACE_SPACE_EN
      s = {s, " "};
`endif
      if (k) s = {s, "*", $sformatf("%08h", addr)};
      else   s = {s, "$", $sformatf("%0d", r)};
`ifdef CPU_TRACE_SPACE_EN
      s = {s, " <= "};
`else
      s = {s, "<="};
`endif
      s = {s, $sformatf("%08h", d), "#"};
      push_str(s);
   endtask

   task automatic drive_rec(input logic k, input logic [15:0] t, input logic [31:0] pc,
                            input logic [4:0] r, input logic [31:0] addr, input logic [31:0] d);
      in_kind = k;
      in_time = t;
      in_pc   = pc;
      in_reg  = r;
      in_addr = addr;
      in_data = d;
   endtask

   task automatic scramble_inputs();
      in_kind = 1'($urandom_range(0, 1));
      in_time = 16'($urandom);
      in_pc   = $urandom;
      in_reg  = 5'($urandom_range(0, 31));
      in_addr = $urandom;
      in_data = $urandom;
   endtask

   // Consume exp_q up to and including the next '#'; mode 0 ready=1, 1 toggle, 2 random.
   task automatic collect_line(input int mode);
      int cyc;
      bit done;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         case (mode)
            0:       char_ready = 1'b1;
            1:       char_ready = ((cyc % 2) == 1);
            default: char_ready = 1'($urandom_range(0, 1));
         endcase
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL line_extra: char=%02h valid=%0b, required end of line", char, char_valid);
            done = 1'b1;
         end else if (char_valid !== 1'b1 || char !== exp_q[0] || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL char_stream: char=%02h valid=%0b in_ready=%0b, required char=%02h valid=1 in_ready=0",
                     char, char_valid, in_ready, exp_q[0]);
         end
         if (!done && char_ready && exp_q.size() != 0) begin
            if (exp_q[0] == 8'h23) begin
               done    = 1'b1;
               exp_cnt = exp_cnt + 16'h0001;
            end
            void'(exp_q.pop_front());
         end
      end
      n_cmp++;
      if (!done) begin
         n_fail++;
         $display("FAIL line_timeout: no '#' accepted within 400 cycles, %0d chars left", exp_q.size());
      end
      @(posedge clk);
      #1;
      char_ready = 1'b0;
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      n_cmp++;
      if (char_valid !== 1'b0 || in_ready !== 1'b1 || rec_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL %s: valid=%0b in_ready=%0b rec_cnt=%0d, required valid=0 in_ready=1 rec_cnt=%0d",
                  name, char_valid, in_ready, rec_cnt, exp_cnt);
      end
   endtask

   // Offer one record, then emit its line; expected characters must already be queued.
   task automatic run_line(input logic k, input logic [15:0] t, input logic [31:0] pc,
                           input logic [4:0] r, input logic [31:0] addr, input logic [31:0] d,
                           input int mode);
      @(negedge clk);
      drive_rec(k, t, pc, r, addr, d);
      in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL accept_ready: in_ready=%0b, required 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scramble_inputs();
      collect_line(mode);
      check_idle("line_end");
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      in_valid   = 1'b0;
      char_ready = 1'b0;
      drive_rec(1'b0, 16'h0, 32'h0, 5'd0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (char !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_char: char=%02h, required 00", char);
      end
      n_cmp++;
      if (char_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_char_valid: %0b, required 0", char_valid);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: %0b, required 1", in_ready);
      end
      n_cmp++;
      if (rec_cnt !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_rec_cnt: %0d, required 0", rec_cnt);
      end
      n_cmp++;
      if (dbg_state !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_state: %0d, required 0 (IDLE)", dbg_state);
      end
      reset = 1'b0;
   endtask

   task automatic test_reg_record();
`ifdef CPU_TRACE_SPACE_EN
      push_str("^10@00003000: $5 <= deadbeef#");
`else
      push_str("^10@00003000:$5<=deadbeef#");
`endif
      run_line(1'b0, 16'h0010, 32'h0000_3000, 5'd5, 32'h1234_5678, 32'hdead_beef, 0);
   endtask

   task automatic test_mem_record();
`ifdef CPU_TRACE_SPACE_EN
      push_str("^0@00004ffc: *00002ffc <= 00000000#");
`else
      push_str("^0@00004ffc:*00002ffc<=00000000#");
`endif
      run_line(1'b1, 16'h0000, 32'h0000_4ffc, 5'd17, 32'h0000_2ffc, 32'h0000_0000, 0);
   endtask

   task automatic test_reg31_time4();
`ifdef CPU_TRACE_SPACE_EN
      push_str("^9999@0000abcd: $31 <= 12345678#");
`else
      push_str("^9999@0000abcd:$31<=12345678#");
`endif
      run_line(1'b0, 16'h9999, 32'h0000_abcd, 5'd31, 32'hffff_ffff, 32'h1234_5678, 0);
   endtask

   task automatic test_backpressure();
`ifdef CPU_TRACE_SPACE_EN
      push_str("^10@00003000: $5 <= deadbeef#");
`else
      push_str("^10@00003000:$5<=deadbeef#");
`endif
      run_line(1'b0, 16'h0010, 32'h0000_3000, 5'd5, 32'h0, 32'hdead_beef, 1);
   endtask

   task automatic test_back_to_back();
      push_model(1'b0, 16'h0042, 32'h8000_0010, 5'd9, 32'h0, 32'hcafe_f00d);
      push_model(1'b1, 16'h0305, 32'h8000_0014, 5'd0, 32'h0001_0abc, 32'h0000_0007);
      @(negedge clk);
      drive_rec(1'b0, 16'h0042, 32'h8000_0010, 5'd9, 32'h0, 32'hcafe_f00d);
      in_valid = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: in_ready=%0b, required 1", in_ready);
      end
      @(posedge clk);
      #1;
      drive_rec(1'b1, 16'h0305, 32'h8000_0014, 5'd0, 32'h0001_0abc, 32'h0000_0007);
      collect_line(0);
      // one idle cycle with the second record still offered
      check_idle("b2b_gap");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      scramble_inputs();
      collect_line(0);
      check_idle("b2b_end");
   endtask

   task automatic test_reset_mid_line();
      bit saw_valid;
      push_model(1'b0, 16'h1234, 32'hfedc_ba98, 5'd12, 32'h0, 32'h0bad_cafe);
      @(negedge clk);
      drive_rec(1'b0, 16'h1234, 32'hfedc_ba98, 5'd12, 32'h0, 32'h0bad_cafe);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // '^1234@' plus three PC digits
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         char_ready = 1'b1;
         n_cmp++;
         if (char_valid !== 1'b1 || char !== exp_q[0]) begin
            n_fail++;
            $display("FAIL pre_reset_char: char=%02h valid=%0b, required char=%02h valid=1",
                     char, char_valid, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      exp_q.delete();
      exp_cnt = 16'h0000;
      n_cmp++;
      if (char_valid !== 1'b0 || in_ready !== 1'b1 || rec_cnt !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_mid_line: valid=%0b in_ready=%0b rec_cnt=%0d, required 0 1 0",
                  char_valid, in_ready, rec_cnt);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (char_valid !== 1'b0) saw_valid = 1'b1;
      end
      n_cmp++;
      if (saw_valid) begin
         n_fail++;
         $display("FAIL reset_no_resume: char_valid seen 1, required 0 after aborted line");
      end
      char_ready = 1'b0;
      check_idle("post_reset_idle");
   endtask

   task automatic test_random();
      logic        k;
      logic [15:0] t;
      logic [31:0] pc;
      logic [4:0]  r;
      logic [31:0] addr;
      logic [31:0] d;
      for (int n = 0; n < 12; n++) begin
         k    = 1'($urandom_range(0, 1));
         t    = 16'($urandom);
         if (n % 3 == 0) t = t & 16'h00ff;
         pc   = $urandom;
         r    = 5'($urandom_range(0, 31));
         addr = $urandom;
         d    = $urandom;
         push_model(k, t, pc, r, addr, d);
         run_line(k, t, pc, r, addr, d, (n % 2 == 0) ? 0 : 2);
      end
   endtask

   initial begin
      test_reset();
      test_reg_record();
      test_mem_record();
      test_reg31_time4();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_line();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
